// File: rtl/axi_ram_arbiter_2to1_pkg.sv
// Shared types for the 2:1 AXI4 RAM arbiter: channel structs, FSM state enums, sizing constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi_ram_arbiter_2to1_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ID_W_WIDTH = 4;
  localparam int ID_R_WIDTH = 4;
  localparam int N_MASTERS  = 2;

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } w_t;

  typedef struct packed {
    logic [ID_W_WIDTH-1:0] id;
    logic [1:0]            resp;
  } b_t;

  typedef struct packed {
    logic [ID_R_WIDTH-1:0] id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_t;

  typedef struct packed {
    logic [ID_R_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_t;

  // Requester -> slave direction of one AXI link.
  typedef struct packed {
    aw_t  aw;
    logic aw_vld;
    w_t   w;
    logic w_vld;
    logic b_rdy;
    ar_t  ar;
    logic ar_vld;
    logic r_rdy;
  } axi_mosi_t;

  // Slave -> requester direction of one AXI link.
  typedef struct packed {
    logic aw_rdy;
    logic w_rdy;
    b_t   b;
    logic b_vld;
    logic ar_rdy;
    r_t   r;
    logic r_vld;
  } axi_miso_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

endpackage

// File: rtl/axi_ram_arbiter_2to1_if.sv
// One AXI4 link bundled as a request struct and a response struct.
// Latency: none, wires only.
// Backpressure: carried inside the structs as the per-channel vld/rdy pairs.
interface axi_ram_arbiter_2to1_if
  import axi_ram_arbiter_2to1_pkg::*;
();
  axi_mosi_t mosi;
  axi_miso_t miso;

  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);
endinterface

// File: rtl/axi_ram_arbiter_2to1_rr_arb2.sv
// Two-way round-robin pick with its priority bit; prio toggles once per completed burst.
// Latency: grant is combinational from req and prio; prio updates on the edge after advance.
// Backpressure: none, a losing requester simply keeps req high.
module rr_arb2
  import axi_ram_arbiter_2to1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 advance,
  output logic                 grant_idx
);
  logic prio;

  // Hand the tie-break to the other master each time a burst finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) prio <= 1'b0;
    else if (advance) prio <= ~prio;
  end

  // The prio master wins a tie; a lone requester wins regardless of prio.
  always_comb begin
    grant_idx = prio;
    if (!req[prio] && req[~prio]) grant_idx = ~prio;
  end
endmodule

// File: rtl/axi_ram_arbiter_2to1.sv
// Shares one AXI4 RAM port between the local CPU (s_axi0) and the mesh (s_axi1); reads and writes arbitrate independently.
// Latency: one IDLE cycle to arbitrate a burst, then zero added latency per beat (pure muxing from the owner register).
// Backpressure: the non-owner sees every READY and response VALID low and holds its request until the owner's burst completes.
module axi_ram_arbiter_2to1
  import axi_ram_arbiter_2to1_pkg::*;
(
  input  logic                          ACLK,
  input  logic                          ARESETn,
  axi_ram_arbiter_2to1_if.slave         s_axi0,
  axi_ram_arbiter_2to1_if.slave         s_axi1,
  axi_ram_arbiter_2to1_if.master        m_axi
);
  axi_mosi_t s_mosi [N_MASTERS];
  assign s_mosi[0] = s_axi0.mosi;
  assign s_mosi[1] = s_axi1.mosi;

  // ---------------- write path ----------------
  w_state_t             w_state, w_state_nxt;
  logic                 w_owner, w_grant, w_done;
  logic                 aw_hs, w_last_hs;
  logic [N_MASTERS-1:0] aw_req;

  aw_t                  m_aw;
  w_t                   m_w;
  logic                 m_aw_vld, m_w_vld, m_b_rdy;
  logic [N_MASTERS-1:0] s_aw_rdy, s_w_rdy, s_b_vld;
  b_t                   s_b [N_MASTERS];

  assign aw_req    = {s_mosi[1].aw_vld, s_mosi[0].aw_vld};
  assign aw_hs     = s_mosi[w_owner].aw_vld & m_axi.miso.aw_rdy;
  assign w_last_hs = s_mosi[w_owner].w_vld & s_mosi[w_owner].w.last & m_axi.miso.w_rdy;
  assign w_done    = (w_state == W_RESP) & m_axi.miso.b_vld & s_mosi[w_owner].b_rdy;

  rr_arb2 u_w_arb (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .req       (aw_req),
    .advance   (w_done),
    .grant_idx (w_grant)
  );

  // Write state and owner; the owner is only captured while idle so it stays fixed for the whole burst.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_owner <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && |aw_req) w_owner <= w_grant;
    end
  end

  // Write sequencing: AW, then W beats until WLAST, then B.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (|aw_req)   w_state_nxt = W_ADDR;
      W_ADDR:  if (aw_hs)     w_state_nxt = W_DATA;
      W_DATA:  if (w_last_hs) w_state_nxt = W_RESP;
      W_RESP:  if (w_done)    w_state_nxt = W_IDLE;
      default:                w_state_nxt = W_IDLE;
    endcase
  end

  // Write muxing: only the channel matching the state is connected, and only for the owner.
  always_comb begin
    m_aw     = '0;
    m_aw_vld = 1'b0;
    m_w      = '0;
    m_w_vld  = 1'b0;
    m_b_rdy  = 1'b0;
    s_aw_rdy = '0;
    s_w_rdy  = '0;
    s_b_vld  = '0;
    s_b[0]   = '0;
    s_b[1]   = '0;
    case (w_state)
      W_ADDR: begin
        m_aw              = s_mosi[w_owner].aw;
        m_aw_vld          = s_mosi[w_owner].aw_vld;
        s_aw_rdy[w_owner] = m_axi.miso.aw_rdy;
      end
      W_DATA: begin
        m_w               = s_mosi[w_owner].w;
        m_w_vld           = s_mosi[w_owner].w_vld;
        s_w_rdy[w_owner]  = m_axi.miso.w_rdy;
      end
      W_RESP: begin
        m_b_rdy           = s_mosi[w_owner].b_rdy;
        s_b[w_owner]      = m_axi.miso.b;
        s_b_vld[w_owner]  = m_axi.miso.b_vld;
      end
      default: ;
    endcase
  end

  // ---------------- read path ----------------
  r_state_t             r_state, r_state_nxt;
  logic                 r_owner, r_grant, r_done;
  logic                 ar_hs;
  logic [N_MASTERS-1:0] ar_req;

  ar_t                  m_ar;
  logic                 m_ar_vld, m_r_rdy;
  logic [N_MASTERS-1:0] s_ar_rdy, s_r_vld;
  r_t                   s_r [N_MASTERS];

  assign ar_req = {s_mosi[1].ar_vld, s_mosi[0].ar_vld};
  assign ar_hs  = s_mosi[r_owner].ar_vld & m_axi.miso.ar_rdy;
  assign r_done = (r_state == R_DATA) & m_axi.miso.r_vld & m_axi.miso.r.last & s_mosi[r_owner].r_rdy;

  rr_arb2 u_r_arb (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .req       (ar_req),
    .advance   (r_done),
    .grant_idx (r_grant)
  );

  // Read state and owner, captured only while idle.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && |ar_req) r_owner <= r_grant;
    end
  end

  // Read sequencing: AR, then R beats until RLAST.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (|ar_req) r_state_nxt = R_ADDR;
      R_ADDR:  if (ar_hs)   r_state_nxt = R_DATA;
      R_DATA:  if (r_done)  r_state_nxt = R_IDLE;
      default:              r_state_nxt = R_IDLE;
    endcase
  end

  // Read muxing: AR forwarded in R_ADDR, R returned to the owner in R_DATA.
  always_comb begin
    m_ar     = '0;
    m_ar_vld = 1'b0;
    m_r_rdy  = 1'b0;
    s_ar_rdy = '0;
    s_r_vld  = '0;
    s_r[0]   = '0;
    s_r[1]   = '0;
    case (r_state)
      R_ADDR: begin
        m_ar              = s_mosi[r_owner].ar;
        m_ar_vld          = s_mosi[r_owner].ar_vld;
        s_ar_rdy[r_owner] = m_axi.miso.ar_rdy;
      end
      R_DATA: begin
        m_r_rdy           = s_mosi[r_owner].r_rdy;
        s_r[r_owner]      = m_axi.miso.r;
        s_r_vld[r_owner]  = m_axi.miso.r_vld;
      end
      default: ;
    endcase
  end

  // ---------------- bus assembly ----------------
  assign m_axi.mosi = '{aw: m_aw, aw_vld: m_aw_vld, w: m_w, w_vld: m_w_vld, b_rdy: m_b_rdy,
                        ar: m_ar, ar_vld: m_ar_vld, r_rdy: m_r_rdy};

  assign s_axi0.miso = '{aw_rdy: s_aw_rdy[0], w_rdy: s_w_rdy[0], b: s_b[0], b_vld: s_b_vld[0],
                         ar_rdy: s_ar_rdy[0], r: s_r[0], r_vld: s_r_vld[0]};

  assign s_axi1.miso = '{aw_rdy: s_aw_rdy[1], w_rdy: s_w_rdy[1], b: s_b[1], b_vld: s_b_vld[1],
                         ar_rdy: s_ar_rdy[1], r: s_r[1], r_vld: s_r_vld[1]};
endmodule

// File: tb/tb_axi_ram_arbiter_2to1.sv
// Directed bench for the 2:1 AXI RAM arbiter with a behavioural RAM slave behind it.
// Latency: n/a.
// Backpressure: the RAM model can withhold B and R via ram_stall.
module tb_axi_ram_arbiter_2to1;
  import axi_ram_arbiter_2to1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m1_hits = 0;

  axi_ram_arbiter_2to1_if s0_if ();
  axi_ram_arbiter_2to1_if s1_if ();
  axi_ram_arbiter_2to1_if m_if ();

  axi_mosi_t mst_mosi [2];
  axi_miso_t mst_miso [2];

  assign s0_if.mosi  = mst_mosi[0];
  assign s1_if.mosi  = mst_mosi[1];
  assign mst_miso[0] = s0_if.miso;
  assign mst_miso[1] = s1_if.miso;

  axi_ram_arbiter_2to1 dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .s_axi0  (s0_if),
    .s_axi1  (s1_if),
    .m_axi   (m_if)
  );

  // ---------------- behavioural RAM slave ----------------
  logic [31:0] mem [1024];
  logic [1:0]  rw_ph;
  logic [9:0]  rw_idx;
  logic [3:0]  rw_id;
  logic        rr_ph;
  logic [9:0]  rr_idx;
  logic [7:0]  rr_cnt, rr_len;
  logic [3:0]  rr_id;
  bit          ram_stall = 1'b0;

  // RAM state: one write burst and one read burst at a time.
  always @(posedge clk) begin
    if (!rst_n) begin
      rw_ph <= 2'd0;
      rr_ph <= 1'b0;
    end else begin
      case (rw_ph)
        2'd0: if (m_if.mosi.aw_vld) begin
          rw_ph  <= 2'd1;
          rw_idx <= m_if.mosi.aw.addr[11:2];
          rw_id  <= m_if.mosi.aw.id;
        end
        2'd1: if (m_if.mosi.w_vld) begin
          mem[rw_idx] <= m_if.mosi.w.data;
          rw_idx      <= rw_idx + 10'd1;
          if (m_if.mosi.w.last) rw_ph <= 2'd2;
        end
        2'd2: if (!ram_stall && m_if.mosi.b_rdy) rw_ph <= 2'd0;
        default: rw_ph <= 2'd0;
      endcase
      if (!rr_ph) begin
        if (m_if.mosi.ar_vld) begin
          rr_ph  <= 1'b1;
          rr_idx <= m_if.mosi.ar.addr[11:2];
          rr_cnt <= 8'd0;
          rr_len <= m_if.mosi.ar.len;
          rr_id  <= m_if.mosi.ar.id;
        end
      end else if (!ram_stall && m_if.mosi.r_rdy) begin
        rr_idx <= rr_idx + 10'd1;
        rr_cnt <= rr_cnt + 8'd1;
        if (rr_cnt == rr_len) rr_ph <= 1'b0;
      end
    end
  end

  // RAM responses.
  always_comb begin
    m_if.miso        = '0;
    m_if.miso.aw_rdy = (rw_ph == 2'd0);
    m_if.miso.w_rdy  = (rw_ph == 2'd1);
    m_if.miso.b_vld  = (rw_ph == 2'd2) && !ram_stall;
    m_if.miso.b.id   = rw_id;
    m_if.miso.ar_rdy = !rr_ph;
    m_if.miso.r_vld  = rr_ph && !ram_stall;
    m_if.miso.r.id   = rr_id;
    m_if.miso.r.data = mem[rr_idx];
    m_if.miso.r.last = (rr_cnt == rr_len);
  end

  // Counts cycles in which master 1 sees anything non-zero.
  always @(negedge clk) begin
    if (mst_miso[1] !== '0) m1_hits <= m1_hits + 1;
  end

  // ---------------- master tasks ----------------
  task automatic apply_reset();
    rst_n       = 1'b0;
    mst_mosi[0] = '0;
    mst_mosi[1] = '0;
    ram_stall   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_write(input int m, input logic [11:0] addr, input logic [3:0] id, input int len,
                          input logic [31:0] d [4], input bit w_first, input bit chk_lat,
                          output time t_done);
    bit got;
    bit early_rdy = 1'b0;
    mst_mosi[m].aw.id    = id;
    mst_mosi[m].aw.addr  = addr;
    mst_mosi[m].aw.len   = 8'(len);
    mst_mosi[m].aw.size  = 3'd2;
    mst_mosi[m].aw.burst = 2'b01;
    mst_mosi[m].aw_vld   = 1'b1;
    mst_mosi[m].w.strb   = 4'hf;
    if (w_first) begin
      mst_mosi[m].w.data = d[0];
      mst_mosi[m].w.last = (len == 0);
      mst_mosi[m].w_vld  = 1'b1;
    end
    if (chk_lat) begin
      @(negedge clk);
      checks++;
      if (m_if.mosi.aw_vld !== 1'b0) begin
        errors++;
        $display("FAIL aw_idle_cycle: ram awvalid=%b, required 0 during arbitration cycle", m_if.mosi.aw_vld);
      end
    end
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (chk_lat && t == 0) begin
        checks++;
        if (m_if.mosi.aw_vld !== 1'b1 || m_if.mosi.aw.addr !== addr) begin
          errors++;
          $display("FAIL aw_forward: ram awvalid=%b awaddr=%h, required 1 and %h one cycle after request",
                   m_if.mosi.aw_vld, m_if.mosi.aw.addr, addr);
        end
      end
      if (w_first && mst_miso[m].w_rdy !== 1'b0) early_rdy = 1'b1;
      got = mst_miso[m].aw_rdy;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL aw_timeout m%0d: no AWREADY, required within 100 cycles", m);
    end
    @(posedge clk); #1;
    mst_mosi[m].aw_vld = 1'b0;
    if (w_first) begin
      checks++;
      if (early_rdy) begin
        errors++;
        $display("FAIL w_before_aw m%0d: WREADY seen 1 before AW handshake, required 0", m);
      end
    end
    for (int b = 0; b <= len; b++) begin
      mst_mosi[m].w.data = d[b];
      mst_mosi[m].w.last = (b == len);
      mst_mosi[m].w_vld  = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = mst_miso[m].w_rdy;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL w_timeout m%0d beat %0d: no WREADY, required within 100 cycles", m, b);
      end
      @(posedge clk); #1;
    end
    mst_mosi[m].w_vld  = 1'b0;
    mst_mosi[m].w.last = 1'b0;
    mst_mosi[m].b_rdy  = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = mst_miso[m].b_vld;
    end
    checks++;
    if (!got || mst_miso[m].b.id !== id || mst_miso[m].b.resp !== 2'b00) begin
      errors++;
      $display("FAIL b_resp m%0d: bvalid=%b bid=%h bresp=%b, required 1 %h 00", m, got,
               mst_miso[m].b.id, mst_miso[m].b.resp, id);
    end
    @(posedge clk); #1;
    mst_mosi[m].b_rdy = 1'b0;
    t_done = $time;
  endtask

  task automatic do_read(input int m, input logic [11:0] addr, input logic [3:0] id, input int len,
                         input logic [31:0] expd [4], output time t_done);
    bit got;
    mst_mosi[m].ar.id    = id;
    mst_mosi[m].ar.addr  = addr;
    mst_mosi[m].ar.len   = 8'(len);
    mst_mosi[m].ar.size  = 3'd2;
    mst_mosi[m].ar.burst = 2'b01;
    mst_mosi[m].ar_vld   = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = mst_miso[m].ar_rdy;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ar_timeout m%0d: no ARREADY, required within 100 cycles", m);
    end
    @(posedge clk); #1;
    mst_mosi[m].ar_vld = 1'b0;
    mst_mosi[m].r_rdy  = 1'b1;
    for (int b = 0; b <= len; b++) begin
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = mst_miso[m].r_vld;
      end
      checks++;
      if (!got || mst_miso[m].r.data !== expd[b] || mst_miso[m].r.last !== (b == len) ||
          mst_miso[m].r.id !== id) begin
        errors++;
        $display("FAIL r_beat m%0d beat %0d: rvalid=%b data=%h last=%b id=%h, required 1 %h %b %h",
                 m, b, got, mst_miso[m].r.data, mst_miso[m].r.last, mst_miso[m].r.id,
                 expd[b], (b == len), id);
      end
      @(posedge clk); #1;
    end
    mst_mosi[m].r_rdy = 1'b0;
    t_done = $time;
  endtask

  // ---------------- scenarios ----------------
  logic [31:0] d1 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] d2 [4] = '{32'hA0A0_0001, 32'hA0A0_0002, 32'h0, 32'h0};
  logic [31:0] d3 [4] = '{32'hB0B0_0001, 32'hB0B0_0002, 32'h0, 32'h0};
  logic [31:0] d4 [4] = '{32'hC001_0000, 32'hC001_0001, 32'hC001_0002, 32'hC001_0003};
  logic [31:0] d5 [4] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
  logic [31:0] d6 [4] = '{32'h5566_7788, 32'h0, 32'h0, 32'h0};
  logic [31:0] d7 [4] = '{32'h7000_0001, 32'h7000_0002, 32'h7000_0003, 32'h7000_0004};

  task automatic test_reset();
    rst_n       = 1'b0;
    mst_mosi[0] = '0;
    mst_mosi[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mst_miso[0] !== '0) begin
      errors++;
      $display("FAIL reset_s0: miso=%h, required 0", mst_miso[0]);
    end
    checks++;
    if (mst_miso[1] !== '0) begin
      errors++;
      $display("FAIL reset_s1: miso=%h, required 0", mst_miso[1]);
    end
    checks++;
    if (m_if.mosi !== '0) begin
      errors++;
      $display("FAIL reset_m: mosi=%h, required 0", m_if.mosi);
    end
    checks++;
    if ({dut.w_owner, dut.r_owner, dut.u_w_arb.prio, dut.u_r_arb.prio} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs: owners/prios=%b, required 0000",
               {dut.w_owner, dut.r_owner, dut.u_w_arb.prio, dut.u_r_arb.prio});
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single_master();
    time t;
    int hits0;
    hits0 = m1_hits;
    do_write(0, 12'h010, 4'h3, 3, d1, 1'b0, 1'b1, t);
    do_read(0, 12'h010, 4'h5, 3, d1, t);
    checks++;
    if (m1_hits !== hits0) begin
      errors++;
      $display("FAIL m1_quiet: master 1 saw %0d active cycles, required 0", m1_hits - hits0);
    end
  endtask

  task automatic test_both_write();
    time t0, t1, t;
    apply_reset();
    fork
      do_write(0, 12'h020, 4'h1, 1, d2, 1'b0, 1'b0, t0);
      do_write(1, 12'h030, 4'h2, 1, d3, 1'b0, 1'b0, t1);
    join
    checks++;
    if (!(t0 < t1)) begin
      errors++;
      $display("FAIL rr_order: m0 done %0t m1 done %0t, required m0 first", t0, t1);
    end
    checks++;
    if (dut.u_w_arb.prio !== 1'b0) begin
      errors++;
      $display("FAIL w_prio_end: w_prio=%b, required 0", dut.u_w_arb.prio);
    end
    do_read(0, 12'h020, 4'h1, 1, d2, t);
    do_read(1, 12'h030, 4'h2, 1, d3, t);
  endtask

  task automatic test_concurrent();
    time tw, tr, t0, t;
    apply_reset();
    t0 = $time;
    fork
      do_write(1, 12'h040, 4'h7, 3, d4, 1'b0, 1'b0, tw);
      do_read(0, 12'h010, 4'h4, 3, d1, tr);
    join
    checks++;
    if (($time - t0) > 100) begin
      errors++;
      $display("FAIL overlap: read+write took %0t time units, required at most 100 (10 cycles)", $time - t0);
    end
    do_read(0, 12'h040, 4'h8, 3, d4, t);
  endtask

  task automatic test_w_before_aw();
    time t;
    apply_reset();
    do_write(0, 12'h050, 4'h9, 2, d7, 1'b1, 1'b0, t);
    do_read(1, 12'h050, 4'hA, 2, d7, t);
  endtask

  task automatic test_stall();
    time ta, tb, tc, td, t;
    bit bad = 1'b0;
    apply_reset();
    fork
      do_read(0, 12'h010, 4'h1, 3, d1, ta);
      do_write(0, 12'h060, 4'h2, 0, d5, 1'b0, 1'b0, tb);
      begin @(posedge clk); #1 do_read(1, 12'h040, 4'h3, 3, d4, tc); end
      begin @(posedge clk); #1 do_write(1, 12'h064, 4'h4, 0, d6, 1'b0, 1'b0, td); end
      begin
        repeat (3) @(posedge clk);
        #1 ram_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (mst_miso[1] !== '0 || mst_miso[0].r_vld !== 1'b0 || mst_miso[0].b_vld !== 1'b0) bad = 1'b1;
        end
        @(posedge clk); #1 ram_stall = 1'b0;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL stall_hold: activity during RAM stall, required m1 idle and m0 B/R VALID 0");
        end
      end
    join
    checks++;
    if (!(ta < tc && tb < td)) begin
      errors++;
      $display("FAIL stall_order: m0 r/w done %0t/%0t, m1 r/w done %0t/%0t, required m0 before m1", ta, tb, tc, td);
    end
    do_read(0, 12'h060, 4'h5, 1, '{32'hDEAD_BEEF, 32'h5566_7788, 32'h0, 32'h0}, t);
  endtask

  task automatic test_reset_mid_burst();
    time t;
    apply_reset();
    mst_mosi[0].aw.id    = 4'h6;
    mst_mosi[0].aw.addr  = 12'h070;
    mst_mosi[0].aw.len   = 8'd3;
    mst_mosi[0].aw.size  = 3'd2;
    mst_mosi[0].aw.burst = 2'b01;
    mst_mosi[0].aw_vld   = 1'b1;
    mst_mosi[0].w.strb   = 4'hf;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mst_miso[0].aw_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_aw: awready=%b, required 1", mst_miso[0].aw_rdy);
    end
    @(posedge clk); #1;
    mst_mosi[0].aw_vld = 1'b0;
    mst_mosi[0].w.data = 32'hFFFF_0001;
    mst_mosi[0].w.last = 1'b0;
    mst_mosi[0].w_vld  = 1'b1;
    @(negedge clk);
    checks++;
    if (mst_miso[0].w_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_w1: wready=%b, required 1", mst_miso[0].w_rdy);
    end
    @(posedge clk); #1;
    mst_mosi[0].w.data = 32'hFFFF_0002;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    mst_mosi[0] = '0;
    @(negedge clk);
    checks++;
    if (mst_miso[0] !== '0 || mst_miso[1] !== '0 || m_if.mosi !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: s0=%h s1=%h m=%h, required all 0", mst_miso[0], mst_miso[1], m_if.mosi);
    end
    @(posedge clk); #1;
    do_write(0, 12'h070, 4'h6, 3, d7, 1'b0, 1'b0, t);
    do_read(0, 12'h070, 4'h6, 3, d7, t);
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_both_write();
    test_concurrent();
    test_w_before_aw();
    test_stall();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
